// File: rtl/sram_if_pkg.sv
// Shared definitions for the 16-bit asynchronous SRAM pin interface:
// FSM encoding of the responder, synchronizer depth limits and the strobe
// bundle type that the ram controller also uses.
package sram_if_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRIVE = 2'd2,
    ST_WRITE = 2'd3
  } sram_state_e;

  // All pin strobes are active-low.
  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic wr_n;
    logic ub_n;
    logic lb_n;
  } sram_strobe_t;

  localparam sram_strobe_t STROBE_IDLE = 5'b11111;

  // Keep the synchronizer depth inside the supported range.
  function automatic int sync_depth(input int n);
    if (n < SYNC_STAGES_MIN) return SYNC_STAGES_MIN;
    if (n > SYNC_STAGES_MAX) return SYNC_STAGES_MAX;
    return n;
  endfunction

  function automatic logic write_strobe(input sram_strobe_t s);
    return ~s.ce_n & ~s.wr_n;
  endfunction

  // A read needs WR high so the bus is never driven against a writer.
  function automatic logic read_strobe(input sram_strobe_t s);
    return ~s.ce_n & ~s.oe_n & s.wr_n;
  endfunction

endpackage

// File: rtl/sram_responder_if.sv
// Control and address pins of the asynchronous SRAM bus. The data bus D is
// bidirectional and stays a plain inout on the responder.
interface sram_responder_if;
  logic        CE;
  logic        OE;
  logic        WR;
  logic        UB;
  logic        LB;
  logic [15:0] A;

  modport master (output CE, OE, WR, UB, LB, A);
  modport slave  (input  CE, OE, WR, UB, LB, A);
endinterface

// File: rtl/sram_responder_mem.sv
// Single-port 2**ADDR_W x 16 RAM with per-byte write enables and a registered,
// write-first read port. Contents are never cleared.
module sram_responder_mem #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        we,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0]  mem_hi [DEPTH];
  logic [7:0]  mem_lo [DEPTH];
  logic [15:0] rdata_d;
  logic [15:0] rdata_q;

  // A byte written this cycle is returned instead of the old contents.
  always_comb begin
    rdata_d[15:8] = we[1] ? wdata[15:8] : mem_hi[addr];
    rdata_d[7:0]  = we[0] ? wdata[7:0]  : mem_lo[addr];
  end

  // Byte-lane writes and read register.
  always_ff @(posedge clk) begin
    if (we[1]) mem_hi[addr] <= wdata[15:8];
    if (we[0]) mem_lo[addr] <= wdata[7:0];
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sram_responder.sv
// Target side of the 16-bit asynchronous SRAM bus, emulating an external SRAM
// in block RAM. Every pin is synchronized to CLK; a small FSM turns the
// synchronized strobes into RAM reads and writes and drives D per byte lane
// from registered enables and registered data.
module sram_responder
  import sram_if_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic            CLK,
  input  logic            RST_N,
  sram_responder_if.slave pins,
  inout  wire  [15:0]     D,
  output logic            wr_pulse,
  output logic            rd_active
);

  localparam int SYNC_N = sync_depth(SYNC_STAGES);

  sram_strobe_t stb_pin;
  sram_strobe_t stb_sync_d [SYNC_N];
  sram_strobe_t stb_sync_q [SYNC_N];
  logic [15:0]  a_sync_d   [SYNC_N];
  logic [15:0]  a_sync_q   [SYNC_N];
  logic [15:0]  d_sync_d   [SYNC_N];
  logic [15:0]  d_sync_q   [SYNC_N];

  sram_strobe_t      stb_s;
  logic [15:0]       a_s;
  logic [15:0]       d_s;
  logic [ADDR_W-1:0] a_word;
  logic              wstb;
  logic              rstb;
  logic              unused_a_hi;

  sram_state_e       state_d, state_q;
  logic              ub_en_d, ub_en_q;
  logic              lb_en_d, lb_en_q;
  logic              fetch_pend_d, fetch_pend_q;
  logic              wr_pulse_d, wr_pulse_q;
  logic [15:0]       dout_d, dout_q;
  logic [ADDR_W-1:0] rd_addr_d, rd_addr_q;
  logic [ADDR_W-1:0] wa_d, wa_q;
  logic [15:0]       wd_d, wd_q;
  logic [1:0]        wbe_d, wbe_q;

  logic              commit;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_we;
  logic [15:0]       mem_q;

  assign stb_pin = {pins.CE, pins.OE, pins.WR, pins.UB, pins.LB};

  // Shift every pin one stage further down its synchronizer chain.
  always_comb begin
    stb_sync_d[0] = stb_pin;
    a_sync_d[0]   = pins.A;
    d_sync_d[0]   = D;
    for (int i = 1; i < SYNC_N; i++) begin
      stb_sync_d[i] = stb_sync_q[i-1];
      a_sync_d[i]   = a_sync_q[i-1];
      d_sync_d[i]   = d_sync_q[i-1];
    end
  end

  // Synchronizer flops; reset to the inactive bus so no strobe edge is seen.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < SYNC_N; i++) begin
        stb_sync_q[i] <= STROBE_IDLE;
        a_sync_q[i]   <= '0;
        d_sync_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < SYNC_N; i++) begin
        stb_sync_q[i] <= stb_sync_d[i];
        a_sync_q[i]   <= a_sync_d[i];
        d_sync_q[i]   <= d_sync_d[i];
      end
    end
  end

  assign stb_s       = stb_sync_q[SYNC_N-1];
  assign a_s         = a_sync_q[SYNC_N-1];
  assign d_s         = d_sync_q[SYNC_N-1];
  assign a_word      = a_s[ADDR_W-1:0];
  assign unused_a_hi = ^(a_s >> ADDR_W);
  assign wstb        = write_strobe(stb_s);
  assign rstb        = read_strobe(stb_s);

  // The write strobe has just fallen: commit the values captured while it was high.
  assign commit   = (state_q == ST_WRITE) && !wstb;
  assign mem_addr = commit ? wa_q : a_word;
  assign mem_we   = commit ? wbe_q : 2'b00;

  sram_responder_mem #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (CLK),
    .addr  (mem_addr),
    .we    (mem_we),
    .wdata (wd_q),
    .rdata (mem_q)
  );

  // Next-state and next-output logic; a write strobe overrides everything.
  always_comb begin
    state_d      = state_q;
    ub_en_d      = ub_en_q;
    lb_en_d      = lb_en_q;
    fetch_pend_d = fetch_pend_q;
    wr_pulse_d   = 1'b0;
    dout_d       = dout_q;
    rd_addr_d    = rd_addr_q;
    wa_d         = wa_q;
    wd_d         = wd_q;
    wbe_d        = wbe_q;
    if (wstb) begin
      state_d      = ST_WRITE;
      ub_en_d      = 1'b0;
      lb_en_d      = 1'b0;
      fetch_pend_d = 1'b0;
      wa_d         = a_word;
      wd_d         = d_s;
      wbe_d        = {~stb_s.ub_n, ~stb_s.lb_n};
    end else begin
      unique case (state_q)
        ST_WRITE: begin
          state_d    = ST_IDLE;
          wr_pulse_d = 1'b1;
        end
        ST_IDLE: begin
          if (rstb) begin
            state_d      = ST_FETCH;
            rd_addr_d    = a_word;
            fetch_pend_d = 1'b1;
          end
        end
        ST_FETCH, ST_DRIVE: begin
          if (!rstb) begin
            state_d      = ST_IDLE;
            ub_en_d      = 1'b0;
            lb_en_d      = 1'b0;
            fetch_pend_d = 1'b0;
          end else begin
            state_d = ST_DRIVE;
            ub_en_d = ~stb_s.ub_n;
            lb_en_d = ~stb_s.lb_n;
            if (fetch_pend_q) dout_d = mem_q;
            // A new address re-issues the read; old data stays on D until it lands.
            if (a_word != rd_addr_q) begin
              rd_addr_d    = a_word;
              fetch_pend_d = 1'b1;
            end else begin
              fetch_pend_d = 1'b0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM state and control outputs; reset releases D asynchronously.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      ub_en_q      <= 1'b0;
      lb_en_q      <= 1'b0;
      fetch_pend_q <= 1'b0;
      wr_pulse_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ub_en_q      <= ub_en_d;
      lb_en_q      <= lb_en_d;
      fetch_pend_q <= fetch_pend_d;
      wr_pulse_q   <= wr_pulse_d;
    end
  end

  // Datapath registers: read data, read address and captured write request.
  always_ff @(posedge CLK) begin
    dout_q    <= dout_d;
    rd_addr_q <= rd_addr_d;
    wa_q      <= wa_d;
    wd_q      <= wd_d;
    wbe_q     <= wbe_d;
  end

  assign D[15:8]   = ub_en_q ? dout_q[15:8] : 8'hzz;
  assign D[7:0]    = lb_en_q ? dout_q[7:0]  : 8'hzz;
  assign rd_active = ub_en_q | lb_en_q;
  assign wr_pulse  = wr_pulse_q;

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: drives the SRAM pins like an asynchronous
// controller, keeps expected reads and write pulses in queues and compares
// them with what the responder produces.
module tb_sram_responder;

  localparam int ADDR_W = 12;
  localparam int SYNC   = 2;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  lanes;
  } rd_exp_t;

  logic        CLK;
  logic        RST_N;
  logic        wr_pulse;
  logic        rd_active;
  logic [15:0] tb_dq;
  logic        tb_den;
  wire  [15:0] D;

  int          n_checks;
  int          n_fail;
  rd_exp_t     rd_q[$];
  logic [15:0] wr_q[$];
  logic [15:0] data_r [4];

  sram_responder_if pins ();

  assign D = tb_den ? tb_dq : 16'hzzzz;

  sram_responder #(
    .ADDR_W      (ADDR_W),
    .SYNC_STAGES (SYNC)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .pins      (pins),
    .D         (D),
    .wr_pulse  (wr_pulse),
    .rd_active (rd_active)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pins_idle();
    pins.CE = 1'b1; pins.OE = 1'b1; pins.WR = 1'b1;
    pins.UB = 1'b1; pins.LB = 1'b1; pins.A  = 16'h0000;
    tb_den  = 1'b0; tb_dq   = 16'h0000;
  endtask

  // Every wr_pulse cycle must match one outstanding write.
  always @(negedge CLK) begin
    if (wr_pulse === 1'b1) begin
      check("wr_pulse_expected", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) void'(wr_q.pop_front());
    end
  end

  task automatic write_word(input logic [15:0] a, input logic [15:0] data, input logic ub,
                            input logic lb, input int wlen, input logic oe);
    pins.A = a; pins.UB = ub; pins.LB = lb; pins.OE = oe;
    pins.CE = 1'b0; pins.WR = 1'b0; tb_dq = data; tb_den = 1'b1;
    wr_q.push_back(a);
    for (int i = 0; i < wlen; i++) begin
      tick(1);
      check("wr_no_drive", 32'(rd_active), 32'd0);
    end
    pins.WR = 1'b1; pins.OE = 1'b1;
    tick(1);
    pins.CE = 1'b1; pins.UB = 1'b1; pins.LB = 1'b1; tb_den = 1'b0;
    for (int i = 0; i < SYNC + 3; i++) begin
      tick(1);
      check("wr_no_drive", 32'(rd_active), 32'd0);
    end
    check("wr_pulse_seen", 32'(wr_q.size()), 32'd0);
  endtask

  task automatic read_word(input string tag, input logic [15:0] a, input logic ub,
                           input logic lb, input logic [15:0] data);
    rd_exp_t     e;
    int          k;
    logic [15:0] mask;
    k = 0;
    pins.A = a; pins.UB = ub; pins.LB = lb; pins.WR = 1'b1; pins.CE = 1'b0; pins.OE = 1'b0;
    e.data  = data;
    e.lanes = {~ub, ~lb};
    rd_q.push_back(e);
    while (!rd_active && k < 20) begin
      tick(1);
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'(SYNC + 2));
    e    = rd_q.pop_front();
    mask = {{8{e.lanes[1]}}, {8{e.lanes[0]}}};
    check({tag, "_lanes"}, 32'({dut.ub_en_q, dut.lb_en_q}), 32'(e.lanes));
    check({tag, "_data"}, 32'(D & mask), 32'(e.data & mask));
  endtask

  task automatic release_read(input string tag);
    int k;
    k = 0;
    pins.OE = 1'b1; pins.CE = 1'b1; pins.UB = 1'b1; pins.LB = 1'b1;
    while (rd_active && k < 20) begin
      tick(1);
      k++;
    end
    check({tag, "_release"}, 32'(!rd_active && k <= SYNC + 1), 32'd1);
    check({tag, "_release_lanes"}, 32'({dut.ub_en_q, dut.lb_en_q}), 32'd0);
  endtask

  // A-step while driving: D must keep old data, then change SYNC+2 cycles later.
  task automatic step_addr(input string tag, input logic [15:0] a, input logic [15:0] old_data,
                           input logic [15:0] new_data);
    rd_exp_t e;
    int      k;
    k = 0;
    pins.A  = a;
    e.data  = new_data;
    e.lanes = 2'b11;
    rd_q.push_back(e);
    while (D === old_data && k < 20) begin
      tick(1);
      k++;
    end
    e = rd_q.pop_front();
    check({tag, "_latency"}, 32'(k), 32'(SYNC + 2));
    check({tag, "_data"}, 32'(D), 32'(e.data));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    pins_idle();
    RST_N = 1'b0;
    tick(3);
    check("reset_rd_active", 32'(rd_active), 32'd0);
    check("reset_wr_pulse", 32'(wr_pulse), 32'd0);
    check("reset_lanes", 32'({dut.ub_en_q, dut.lb_en_q}), 32'd0);
    RST_N = 1'b1;
    tick(2);

    // Basic write then read.
    write_word(16'h0010, 16'h1234, 1'b0, 1'b0, 4, 1'b1);
    read_word("t1_read", 16'h0010, 1'b0, 1'b0, 16'h1234);
    release_read("t1");

    // Upper byte only, then a lower-lane-only read.
    write_word(16'h0010, 16'hAB00, 1'b0, 1'b1, 4, 1'b1);
    read_word("t2_read", 16'h0010, 1'b0, 1'b0, 16'hAB34);
    release_read("t2");
    read_word("t2_lb_only", 16'h0010, 1'b1, 1'b0, 16'hAB34);
    release_read("t2_lb");

    // OE low during a write never drives D.
    write_word(16'h0020, 16'h7777, 1'b0, 1'b0, 4, 1'b0);
    read_word("t3_read", 16'h0020, 1'b0, 1'b0, 16'h7777);
    release_read("t3");

    // Address wraps modulo 2**ADDR_W; a write with both lanes off changes nothing.
    write_word(16'h1010, 16'h5555, 1'b0, 1'b0, 4, 1'b1);
    read_word("t4_wrap", 16'h0010, 1'b0, 1'b0, 16'h5555);
    release_read("t4");
    write_word(16'h0010, 16'h0000, 1'b1, 1'b1, 4, 1'b1);
    read_word("t4_nolane", 16'h0010, 1'b0, 1'b0, 16'h5555);
    release_read("t4_nolane");

    // Address steps while OE stays low.
    write_word(16'h0001, 16'h1111, 1'b0, 1'b0, 4, 1'b1);
    write_word(16'h0002, 16'h2222, 1'b0, 1'b0, 4, 1'b1);
    read_word("t5_read", 16'h0001, 1'b0, 1'b0, 16'h1111);
    step_addr("t5_step12", 16'h0002, 16'h1111, 16'h2222);
    step_addr("t5_step21", 16'h0001, 16'h2222, 16'h1111);
    release_read("t5");

    // Random data with minimum-length write pulses.
    for (int i = 0; i < 4; i++) begin
      data_r[i] = 16'($urandom);
      write_word(16'h0100 + 16'(i), data_r[i], 1'b0, 1'b0, SYNC + 1, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      read_word("rand_read", 16'h0100 + 16'(i), 1'b0, 1'b0, data_r[i]);
      release_read("rand");
    end

    // Reset in the middle of a write drops it.
    write_word(16'h0030, 16'h3C3C, 1'b0, 1'b0, 4, 1'b1);
    pins.A = 16'h0030; tb_dq = 16'hDEAD; tb_den = 1'b1;
    pins.UB = 1'b0; pins.LB = 1'b0; pins.CE = 1'b0; pins.WR = 1'b0;
    tick(4);
    RST_N = 1'b0;
    #1;
    check("t6_wr_reset_pulse", 32'(wr_pulse), 32'd0);
    check("t6_wr_reset_rd_active", 32'(rd_active), 32'd0);
    pins_idle();
    tick(2);
    RST_N = 1'b1;
    tick(SYNC + 3);
    read_word("t6_kept", 16'h0030, 1'b0, 1'b0, 16'h3C3C);

    // Reset in the middle of a read releases D at once.
    RST_N = 1'b0;
    #1;
    check("t6_rd_reset_rd_active", 32'(rd_active), 32'd0);
    check("t6_rd_reset_lanes", 32'({dut.ub_en_q, dut.lb_en_q}), 32'd0);
    pins_idle();
    tick(2);
    RST_N = 1'b1;
    tick(SYNC + 3);
    check("t6_after_reset_rd_active", 32'(rd_active), 32'd0);
    check("t6_no_stray_write", 32'(wr_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
